// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: round-robin sharing of one multi-cycle multiplier between integer and FPU requesters
// Ports: clk/clr clock and sync reset; int_*/fpu_* requester handshakes (req, operands, done, product);
// mul_* start/done interface to the shared multiplier; busy, grant (0=int, 1=fpu) and fault (timeout abort).
module multiplier_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               int_req,
  input  logic [WIDTH-1:0]   int_a,
  input  logic [WIDTH-1:0]   int_b,
  output logic               int_done,
  output logic [2*WIDTH-1:0] int_product,
  input  logic               fpu_req,
  input  logic [WIDTH-1:0]   fpu_a,
  input  logic [WIDTH-1:0]   fpu_b,
  output logic               fpu_done,
  output logic [2*WIDTH-1:0] fpu_product,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               busy,
  output logic               grant,
  output logic               fault
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
  state_t state, state_nx;
  logic last_grant, fault_q, pick, take, capture, abort;
  logic [7:0] cnt;
  always_comb begin
    pick     = (int_req && fpu_req) ? ~last_grant : fpu_req;
    take     = state == IDLE && (int_req || fpu_req);
    capture  = (state == ISSUE || state == WAIT) && mul_done;
    abort    = state == WAIT && !mul_done && cnt == 8'(TIMEOUT - 1);
    state_nx = take ? ISSUE :
               state == ISSUE ? (mul_done ? RESPOND : WAIT) :
               state == WAIT ? ((mul_done || abort) ? RESPOND : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      mul_a       <= '0;
      mul_b       <= '0;
      int_product <= '0;
      fpu_product <= '0;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      fault_q     <= 1'b0;
      cnt         <= '0;
    end else begin
      state   <= state_nx;
      fault_q <= abort;
      if (take) begin
        mul_a      <= pick ? fpu_a : int_a;
        mul_b      <= pick ? fpu_b : int_b;
        grant      <= pick;
        last_grant <= pick;
      end
      if (state == ISSUE) cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 8'd1;
      if ((capture || abort) && grant) fpu_product <= abort ? '0 : mul_product;
      if ((capture || abort) && !grant) int_product <= abort ? '0 : mul_product;
    end
  end
  assign mul_start = state == ISSUE;
  assign busy      = state != IDLE;
  assign int_done  = state == RESPOND && !grant;
  assign fpu_done  = state == RESPOND && grant;
  assign fault     = state == RESPOND && fault_q;
endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb_multiplier_arbiter: directed self-checking bench for multiplier_arbiter with a mock latency multiplier
module tb_multiplier_arbiter;
  logic        clk = 0, clr = 1;
  logic        int_req = 0, fpu_req = 0;
  logic [31:0] int_a = 0, int_b = 0, fpu_a = 0, fpu_b = 0;
  logic        int_done, fpu_done, mul_start, mul_done, busy, grant, fault;
  logic [63:0] int_product, fpu_product, mul_product;
  logic [31:0] mul_a, mul_b;
  int          checks = 0, failures = 0;
  int          lat = 3;
  logic        mock_en = 1, pending = 0;
  int          rem = 0;
  int          done_cyc[3];
  int          nd;

  multiplier_arbiter #(.WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .clr(clr),
    .int_req(int_req), .int_a(int_a), .int_b(int_b), .int_done(int_done), .int_product(int_product),
    .fpu_req(fpu_req), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_done(fpu_done), .fpu_product(fpu_product),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_product(mul_product),
    .busy(busy), .grant(grant), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_start && lat > 0) begin
      pending <= 1;
      rem     <= lat - 1;
    end else if (pending) begin
      if (rem == 0) pending <= 0;
      else rem <= rem - 1;
    end
  end
  assign mul_done    = mock_en && ((mul_start && lat == 0) || (pending && rem == 0));
  assign mul_product = 64'(mul_a) * 64'(mul_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    clr = 0;
    check("reset_busy", busy, 0);
    check("reset_grant", grant, 0);
    check("reset_int_product", int_product, 0);
    check("reset_mul_a", mul_a, 0);

    lat = 3; int_req = 1; int_a = 6; int_b = 7;
    step();
    step();
    clr = 1; int_req = 0;
    step();
    clr = 0;
    for (int c = 3; c <= 7; c++) begin
      check($sformatf("rst_busy_c%0d", c), busy, 0);
      check($sformatf("rst_int_done_c%0d", c), int_done, 0);
      check($sformatf("rst_int_product_c%0d", c), int_product, 0);
      step();
    end

    int_req = 1; int_a = 6; int_b = 7;
    for (int c = 1; c <= 6; c++) begin
      step();
      check($sformatf("int_start_c%0d", c), mul_start, c == 1);
      check($sformatf("int_busy_c%0d", c), busy, c <= 5);
      check($sformatf("int_done_c%0d", c), int_done, c == 5);
      check($sformatf("int_fpu_done_c%0d", c), fpu_done, 0);
      if (c == 5) begin
        check("int_product", int_product, 64'd42);
        int_req = 0;
      end
    end

    lat = 0; fpu_req = 1; fpu_a = 32'h0080_0000; fpu_b = 32'h0080_0000;
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("fpu_done_c%0d", c), fpu_done, c == 2);
      if (c == 2) begin
        check("fpu_product", fpu_product, 64'h0000_4000_0000_0000);
        check("fpu_grant", grant, 1);
        check("fpu_int_done", int_done, 0);
        fpu_req = 0;
      end
    end

    lat = 1; nd = 0;
    int_req = 1; int_a = 2; int_b = 3;
    fpu_req = 1; fpu_a = 32'h00C0_0000; fpu_b = 32'h0080_0000;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (int_done || fpu_done) begin
        if (nd < 3) done_cyc[nd] = c;
        check($sformatf("rr_grant_%0d", nd), grant, nd == 1);
        check($sformatf("rr_int_done_%0d", nd), int_done, nd != 1);
        nd++;
      end
    end
    int_req = 0; fpu_req = 0;
    check("rr_count", nd, 3);
    check("rr_int_product", int_product, 64'd6);
    check("rr_fpu_product", fpu_product, 64'h0000_6000_0000_0000);
    check("rr_spacing_1", done_cyc[1] - done_cyc[0], 4);
    check("rr_spacing_2", done_cyc[2] - done_cyc[1], 4);
    step();

    mock_en = 0; int_req = 1; int_a = 5; int_b = 5;
    for (int c = 1; c <= 7; c++) begin
      step();
      check($sformatf("to_done_c%0d", c), int_done, c == 6);
      check($sformatf("to_fault_c%0d", c), fault, c == 6);
      check($sformatf("to_busy_c%0d", c), busy, c <= 6);
      if (c == 6) begin
        check("to_int_product", int_product, 0);
        int_req = 0;
      end
    end

    mock_en = 1; lat = 1; int_req = 1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("post_done_c%0d", c), int_done, c == 3);
      check($sformatf("post_fault_c%0d", c), fault, 0);
      if (c == 3) begin
        check("post_int_product", int_product, 64'd25);
        int_req = 0;
      end
    end
    step();
    check("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multiplier_arbiter.md
Name: multiplier_arbiter

Overview:
- Shares the single ALU 32x32 multiplier between two requesters: the integer MUL path of the CPU datapath and the FPU multiplier, which supplies 24-bit mantissas and expects a 64-bit product.
- Multi-cycle handshake controller: round-robin grant, operand/product registers, watchdog timeout.
- Sits between both requesters and the shared multiplier's start/done interface.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- TIMEOUT, 64, max cycles in WAIT before abort; range 2..255.

Ports:
- clk  in  1  clock, all state updates on rising edge
- clr  in  1  synchronous active-high reset
- int_req  in  1  integer requester holds high with stable operands until int_done
- int_a, int_b  in  WIDTH  integer operands
- int_done  out  1  one-cycle completion pulse
- int_product  out  2*WIDTH  registered result, held until next int completion
- fpu_req, fpu_a, fpu_b, fpu_done, fpu_product  same as int_* for the FPU requester
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_a, mul_b  out  WIDTH  registered operands; stable from ISSUE through WAIT
- mul_done  in  1  multiplier completion; mul_product valid in that cycle
- mul_product  in  2*WIDTH  multiplier result
- busy  out  1  high in any state other than IDLE
- grant  out  1  0 = integer, 1 = FPU; owner of current/last operation
- fault  out  1  one-cycle pulse, coincident with done, on timeout abort

Behaviour:
- Reset: on clr=1 at an edge:
  - state=IDLE; mul_a, mul_b, int_product, fpu_product = 0.
  - All pulses = 0; grant=0; last_grant=1, so the integer requester wins the first tie.
  - Timeout counter = 0.
  - clr overrides every other input and aborts any in-flight operation silently: no done, no fault. A late mul_done after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both: grant = ~last_grant.
  - On grant, latch the granted operands into mul_a/mul_b, set grant and last_grant, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mul_start=1.
  - If mul_done=1 this cycle, capture the product and go to RESPOND.
  - Otherwise go to WAIT and clear the counter.
- WAIT:
  - mul_start=0; counter increments each cycle.
  - On mul_done=1: capture mul_product into the granted requester's product register, go to RESPOND.
  - If counter reaches TIMEOUT-1 without mul_done: write 0 to the product register, set the fault flag, go to RESPOND.
- RESPOND (exactly 1 cycle):
  - Granted requester's done=1; fault=1 if aborted.
  - Next state always IDLE; requests are not sampled in RESPOND.
- Requester rule: drop req on the edge at which done is sampled high. req still high in the IDLE cycle after RESPOND is a new request.
- Dropping req mid-operation does not cancel it: the multiplier completes, done still pulses, and the product register updates.
- Non-granted product register and done stay unchanged.
- mul_done outside ISSUE/WAIT is ignored.
- Latency:
  - req sampled at edge n → mul_start in cycle n+1.
  - Multiplier done L cycles after start (L≥0) → done in cycle n+2+L.
  - Minimum 2 cycles.
- Throughput: one operation per 3+L cycles. A continuously requesting pair alternates strictly.
- Widths: operands pass through unmodified. Zero-extension of FPU mantissas is the requester's job.

Test Plan:
- Reset mid-WAIT, mock latency 3:
  - int_req with 6, 7; clr pulsed in the first WAIT cycle.
  - Expect state IDLE, busy=0, no int_done, int_product=0, late mul_done ignored.
- Single integer op, mock latency 3:
  - int_req=1, a=6, b=7 at cycle 0.
  - Expect mul_start in cycle 1 only; int_done pulse in cycle 5; int_product=42; fpu_done never asserted; busy=1 for cycles 1-5.
- Single FPU op, latency 0 (mul_done in the ISSUE cycle):
  - fpu_a=0x00800000, fpu_b=0x00800000.
  - Expect fpu_done in cycle 2; fpu_product=0x0000400000000000; grant=1.
- Simultaneous requests held high for three operations, latency 1:
  - Int 2x3, FPU 0x00C00000x0x00800000.
  - Expect grant order int, fpu, int.
  - Expect int_product=6 and fpu_product=0x0000600000000000.
  - Expect a 4-cycle spacing between done pulses.
- Timeout, TIMEOUT=4, mock never asserts mul_done:
  - int_req with 5, 5.
  - Expect int_done and fault together in cycle 6, int_product=0, then IDLE.
  - A following op with working mock returns 25 with fault=0.
